div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//  Multi-cycle signed divider; the inverse operation of the combinational multiplier unit in the execute stage.
//  Restoring radix-2 algorithm on operand magnitudes: one quotient bit per clock, sign fixed up at the end.
//  Sits beside the multiplier in the multdiv path; the pipeline stalls on data_busy and resumes on data_resultRDY.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; iteration count equals WIDTH
// PORTS
//  clock           in   1      single clock, rising edge
//  reset           in   1      asynchronous, active-high; clears all state
//  ctrl_DIV        in   1      start strobe, sampled only in IDLE
//  data_operandA   in   WIDTH  dividend, two's complement
//  data_operandB   in   WIDTH  divisor, two's complement
//  data_result     out  WIDTH  quotient, truncated toward zero
//  data_remainder  out  WIDTH  remainder; sign follows dividend; |rem| < |divisor|
//  data_exception  out  1      divide-by-zero or overflow
//  data_resultRDY  out  1      one-cycle pulse: result/remainder/exception valid
//  data_busy       out  1      high from the edge after start through the final iteration
// BEHAVIOUR
//  Reset: state=IDLE; data_result, data_remainder=0; data_exception, data_resultRDY, data_busy=0.
//  Reset asserted mid-operation aborts the operation. No RDY pulse is issued and outputs are zeroed.
//  States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE, edge E, ctrl_DIV=1, B!=0: latch sign(A)^sign(B), sign(A), |A|, |B|; count=0; rem=0; -> RUN.
//   IDLE, edge E, ctrl_DIV=1, B==0: result=0, remainder=A, exception=1, RDY=1; stay IDLE.
//   RUN: each edge does {rem,q}<<=1; if rem>=|B| then rem-=|B|, q[0]=1; count++.
//    After WIDTH iterations (edges E+1..E+WIDTH) -> DONE.
//   DONE, edge E+WIDTH+1: result = qsign ? -q : q; remainder = asign ? -rem : rem; RDY=1; -> IDLE.
//  Latency: start sampled at edge E; RDY high in the cycle after edge E+WIDTH+1, i.e. 33 cycles for WIDTH=32.
//  data_busy: 1 in RUN and DONE, 0 in IDLE.
//  ctrl_DIV during RUN/DONE: ignored, not queued. A new start is accepted on the first IDLE cycle, which may be
//   the same cycle RDY is high, giving back-to-back operation.
//  Operands are sampled only at start; later changes on data_operandA/B have no effect.
//  Magnitudes use WIDTH+1 bits internally so |-2^(WIDTH-1)| is exact. Subtractor is WIDTH+1 bits; no carry loss.
//  Overflow: A=-2^(WIDTH-1), B=-1 gives result=0x80000000 (wraps), remainder=0, exception=1.
//  Exception is 0 for all other B!=0 cases.
//  data_result, data_remainder and data_exception hold their values until the next completion or reset.
//  data_resultRDY is 0 in every cycle except the single completion cycle.
// STRUCTURE
//  Shared package: state encoding (IDLE/RUN/DONE, 2 bits); WIDTH default; iteration-counter width = clog2(WIDTH)+1.
//  Sub-module div_step: one combinational restoring step; in rem, q, divisor; out next rem, next q.
//  Reuse the existing neg32 for operand magnitude and result sign fix-up. Counter and FSM live in div_seq.
// TESTING
//  1. 100 / 7 -> result=14, remainder=2, exception=0; RDY exactly 33 cycles after start.
//  2. -100 / 7 -> -14 r -2; 100 / -7 -> -14 r 2; -100 / -7 -> 14 r -2.
//  3. 5 / 0 -> one cycle after start: result=0, remainder=5, exception=1, RDY=1, busy stays 0.
//  4. 0x80000000 / 0xFFFFFFFF -> result=0x80000000, exception=1.
//     0x80000000 / 1 -> 0x80000000 with exception=0.
//  5. Start, pulse ctrl_DIV at cycle 10 with different operands -> ignored; first result unaffected.
//     Restart in the RDY cycle completes 33 cycles later.
//  6. Reset at cycle 15 of an operation -> outputs 0, no RDY; a fresh 7/2 afterwards -> 3 r 1.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential signed divider:
// FSM state encoding, default width and iteration-counter sizing.
package div_seq_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/response bundle between the pipeline multdiv path and the divider.
interface div_seq_if
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;
    logic             data_busy;

    modport master (
        output ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_remainder, data_exception, data_resultRDY, data_busy
    );

    modport slave (
        input  ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_remainder, data_exception, data_resultRDY, data_busy
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,q} left, subtract if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH:0]   divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted  = {rem, q[WIDTH-1]};
        diff     = shifted - {1'b0, divisor};
        q_next   = {q[WIDTH-2:0], 1'b0};
        rem_next = shifted[WIDTH:0];
        // both operands stay below 2^(WIDTH+1), so the top bit of diff is a clean borrow
        if (!diff[WIDTH+1]) begin
            rem_next  = diff[WIDTH:0];
            q_next[0] = 1'b1;
        end
    end
endmodule

// File: rtl/neg32.sv
// Two's complement negation, shared by magnitude extraction and sign fix-up.
module neg32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);
    assign y = '0 - a;
endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed restoring divider: one quotient bit per clock on operand
// magnitudes, with quotient/remainder sign fix-up on completion.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic      clock,
    input logic      reset,
    div_seq_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_n;
    logic             qsign;
    logic             asign;
    logic             ovf;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   divisor;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] neg_a;
    logic [WIDTH-1:0] neg_b;
    logic [WIDTH-1:0] neg_q;
    logic [WIDTH-1:0] neg_r;
    logic             sign_a;
    logic             sign_b;
    logic             b_zero;
    logic             last;
    logic             is_ovf;

    neg32 #(.WIDTH(WIDTH)) u_neg_a (.a(bus.data_operandA), .y(neg_a));
    neg32 #(.WIDTH(WIDTH)) u_neg_b (.a(bus.data_operandB), .y(neg_b));
    neg32 #(.WIDTH(WIDTH)) u_neg_q (.a(q),                 .y(neg_q));
    neg32 #(.WIDTH(WIDTH)) u_neg_r (.a(rem[WIDTH-1:0]),    .y(neg_r));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .q        (q),
        .divisor  (divisor),
        .rem_next (rem_nx),
        .q_next   (q_nx)
    );

    assign sign_a = bus.data_operandA[WIDTH-1];
    assign sign_b = bus.data_operandB[WIDTH-1];
    assign b_zero = (bus.data_operandB == '0);
    assign last   = (count == CW'(WIDTH - 1));
    assign is_ovf = (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.data_operandB == '1);

    assign bus.data_busy = (state != S_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (bus.ctrl_DIV && !b_zero) state_n = S_RUN;
            S_RUN:   if (last) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            qsign              <= 1'b0;
            asign              <= 1'b0;
            ovf                <= 1'b0;
            rem                <= '0;
            divisor            <= '0;
            q                  <= '0;
            count              <= '0;
            bus.data_result    <= '0;
            bus.data_remainder <= '0;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b0;
        end else begin
            bus.data_resultRDY <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.ctrl_DIV) begin
                        if (b_zero) begin
                            bus.data_result    <= '0;
                            bus.data_remainder <= bus.data_operandA;
                            bus.data_exception <= 1'b1;
                            bus.data_resultRDY <= 1'b1;
                        end else begin
                            // |A| fits unsigned in WIDTH bits, including the most negative value
                            qsign   <= sign_a ^ sign_b;
                            asign   <= sign_a;
                            ovf     <= is_ovf;
                            q       <= sign_a ? neg_a : bus.data_operandA;
                            divisor <= {1'b0, (sign_b ? neg_b : bus.data_operandB)};
                            rem     <= '0;
                            count   <= '0;
                        end
                    end
                end
                S_RUN: begin
                    rem   <= rem_nx;
                    q     <= q_nx;
                    count <= count + 1'b1;
                end
                S_DONE: begin
                    bus.data_result    <= qsign ? neg_q : q;
                    bus.data_remainder <= asign ? neg_r : rem[WIDTH-1:0];
                    bus.data_exception <= ovf;
                    bus.data_resultRDY <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: arithmetic reference model compared every
// cycle, plus directed cases with hand-computed results and latency.
module tb_div_seq;
    localparam int W = 32;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    div_seq_if #(.WIDTH(W)) bus();

    div_seq #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference arithmetic: truncating division, remainder takes dividend sign
    function automatic void model_div(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic [31:0] rm,
                                      output logic e);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            r = '0; rm = a; e = 1'b1;
        end else begin
            r  = 32'(sa / sb);
            rm = 32'(sa % sb);
            e  = (sa == -64'sd2147483648) && (sb == -64'sd1);
        end
    endfunction

    bit          m_active;
    int          m_cnt;
    logic [31:0] m_res, m_rem, p_res, p_rem;
    logic        m_exc, p_exc, m_rdy;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active = 1'b0; m_cnt = 0;
            m_res = '0; m_rem = '0; m_exc = 1'b0; m_rdy = 1'b0;
        end else begin
            m_rdy = 1'b0;
            if (m_active) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_active = 1'b0;
                    m_res = p_res; m_rem = p_rem; m_exc = p_exc; m_rdy = 1'b1;
                end
            end else if (bus.ctrl_DIV === 1'b1) begin
                model_div(bus.data_operandA, bus.data_operandB, p_res, p_rem, p_exc);
                if (bus.data_operandB == '0) begin
                    m_res = p_res; m_rem = p_rem; m_exc = p_exc; m_rdy = 1'b1;
                end else begin
                    m_active = 1'b1;
                    m_cnt = W + 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("busy",      bus.data_busy,      m_active);
            check("rdy",       bus.data_resultRDY, m_rdy);
            check("result",    bus.data_result,    m_res);
            check("remainder", bus.data_remainder, m_rem);
            check("exception", bus.data_exception, m_exc);
        end
    end

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit lit,
                           input logic [31:0] er, input logic [31:0] erm, input logic ee,
                           input bit noise, input bit from_rdy);
        int lat;
        int elat;
        elat = (b == '0) ? 0 : 33;
        if (!from_rdy) @(negedge clock);
        bus.ctrl_DIV = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        @(negedge clock);
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        lat = 0;
        while (bus.data_resultRDY !== 1'b1 && lat < 100) begin
            bus.ctrl_DIV = noise && (lat == 9);
            @(negedge clock);
            lat++;
        end
        bus.ctrl_DIV = 1'b0;
        check("latency", lat, elat);
        if (elat == 0) check("busy_div0", bus.data_busy, 1'b0);
        if (lit) begin
            check("lit_result",    bus.data_result,    er);
            check("lit_remainder", bus.data_remainder, erm);
            check("lit_exception", bus.data_exception, ee);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rdy_seen;
        logic [31:0] a, b;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_result", bus.data_result, 32'h0);
        check("rst_rdy",    bus.data_resultRDY, 1'b0);
        check("rst_busy",   bus.data_busy, 1'b0);
        chk_en = 1'b1;
        #2 reset = 1'b0;

        run_div(32'd100, 32'd7, 1, 32'd14, 32'd2, 0, 0, 0);
        run_div(-32'sd100, 32'd7, 1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, 0, 0);
        run_div(32'd100, -32'sd7, 1, 32'hFFFF_FFF2, 32'd2, 0, 0, 0);
        run_div(-32'sd100, -32'sd7, 1, 32'd14, 32'hFFFF_FFFE, 0, 0, 0);
        run_div(32'd5, 32'd0, 1, 32'd0, 32'd5, 1, 0, 0);
        run_div(MIN_INT, 32'hFFFF_FFFF, 1, MIN_INT, 32'd0, 1, 0, 0);
        run_div(MIN_INT, 32'd1, 1, MIN_INT, 32'd0, 0, 0, 0);
        run_div(32'd100, 32'd7, 1, 32'd14, 32'd2, 0, 1, 0);
        run_div(32'd1000, 32'd33, 1, 32'd30, 32'd10, 0, 0, 1);

        // Abort mid-operation with reset
        @(negedge clock);
        bus.ctrl_DIV = 1'b1;
        bus.data_operandA = 32'd999;
        bus.data_operandB = 32'd4;
        @(posedge clock);
        @(negedge clock);
        bus.ctrl_DIV = 1'b0;
        repeat (14) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_result",    bus.data_result,    32'h0);
        check("abort_remainder", bus.data_remainder, 32'h0);
        check("abort_busy",      bus.data_busy,      1'b0);
        @(negedge clock);
        #2 reset = 1'b0;
        rdy_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) rdy_seen++;
        end
        check("abort_no_rdy", rdy_seen, 0);
        run_div(32'd7, 32'd2, 1, 32'd3, 32'd1, 0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            if ($urandom_range(0, 9) == 0) a = MIN_INT;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 15));
                4:       b = 32'($urandom) >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            run_div(a, b, 0, '0, '0, 0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
